// File: rtl/imem_loader_if.sv
// Wishbone classic slave bus for the instruction-memory loader.
interface imem_loader_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/imem_loader.sv
// Wishbone-to-SRAM bridge that loads a core's instruction memory while holding
// the core in reset; CTRL.RUN releases the core and locks out further loads.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  imem_loader_if.slave wbs,
  output logic        csb0_o,
  output logic        web0_o,
  output logic [3:0]  wmask0_o,
  output logic [8:0]  addr0_o,
  output logic [31:0] din0_o,
  input  logic [31:0] dout0_i,
  output logic        core_rst_n_o
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR   = 3'd1;
  localparam logic [2:0] RD1  = 3'd2;
  localparam logic [2:0] RD2  = 3'd3;
  localparam logic [2:0] ACK  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] dat_q, dat_d;
  logic        run_q, run_d;
  logic        err_q, err_d;
  logic [9:0]  wcnt_q, wcnt_d;
  logic        core_q, core_d;

  logic        hit;
  logic        is_reg;
  logic [31:0] reg_rdata;
  logic        unused_adr;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  assign hit        = wbs.wbs_cyc_i && wbs.wbs_stb_i &&
                      (wbs.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign is_reg     = wbs.wbs_adr_i[11];
  assign unused_adr = ^wbs.wbs_adr_i[1:0];

  always_comb begin
    reg_rdata = 32'h0;
    case (wbs.wbs_adr_i[3:2])
      2'd0:    reg_rdata = {30'h0, err_q, run_q};
      2'd1:    reg_rdata = {22'h0, wcnt_q};
      default: reg_rdata = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    mask_d  = mask_q;
    dat_d   = dat_q;
    run_d   = run_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
    // One extra stage so the core leaves reset the cycle after the CTRL ack.
    core_d  = run_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          if (is_reg) begin
            state_d = ACK;
            if (wbs.wbs_we_i) begin
              dat_d = 32'h0;
              if (wbs.wbs_adr_i[3:2] == 2'd0) begin
                run_d = wbs.wbs_dat_i[0];
                err_d = err_q & ~wbs.wbs_dat_i[1];
              end else if (wbs.wbs_adr_i[3:2] == 2'd1) begin
                wcnt_d = 10'h0;
              end
            end else begin
              dat_d = reg_rdata;
            end
          end else if (wbs.wbs_we_i) begin
            if (run_q) begin
              // Image is locked once the core runs: ack but flag the attempt.
              state_d = ACK;
              err_d   = 1'b1;
              dat_d   = 32'h0;
            end else begin
              state_d = WR;
              addr_d  = wbs.wbs_adr_i[10:2];
              din_d   = wbs.wbs_dat_i;
              mask_d  = wbs.wbs_sel_i;
            end
          end else begin
            state_d = RD1;
            addr_d  = wbs.wbs_adr_i[10:2];
          end
        end
      end
      WR: begin
        if (!wbs.wbs_cyc_i) begin
          state_d = IDLE;
        end else begin
          state_d = ACK;
          dat_d   = 32'h0;
          wcnt_d  = sat_inc(wcnt_q);
        end
      end
      RD1: state_d = wbs.wbs_cyc_i ? RD2 : IDLE;
      RD2: begin
        if (!wbs.wbs_cyc_i) begin
          state_d = IDLE;
        end else begin
          state_d = ACK;
          dat_d   = dout0_i;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      addr_q  <= 9'h0;
      din_q   <= 32'h0;
      mask_q  <= 4'h0;
      dat_q   <= 32'h0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= 10'h0;
      core_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      mask_q  <= mask_d;
      dat_q   <= dat_d;
      run_q   <= run_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
      core_q  <= core_d;
    end
  end

  assign csb0_o        = !((state_q == WR) || (state_q == RD1));
  assign web0_o        = (state_q != WR);
  assign wmask0_o      = (state_q == WR) ? mask_q : 4'h0;
  assign addr0_o       = addr_q;
  assign din0_o        = din_q;
  assign core_rst_n_o  = core_q;
  assign wbs.wbs_ack_o = (state_q == ACK);
  assign wbs.wbs_dat_o = dat_q;

endmodule
